// File: rtl/kcpe_scheduler.sv
// kcpe_scheduler
// Sequencing controller for the kernel-channel PE (NUM_CHANNEL x NUM_KERNEL MAC
// array). For every output pixel it walks all channel groups. For each group it
// fetches one data word and one weight word, presents them to the array together
// with the running psum, and captures the array result as the next group's psum.
// The finished pixel result goes to the output stage over a valid/ready handshake.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   i_start, i_num_cgrp, i_num_pix job start pulse and job dimensions
//   o_buf_rd, o_data_addr,
//   o_weight_addr                  buffer read request (data 1 cycle later)
//   i_buf_data, i_buf_weight       buffer read results
//   o_pe_data, o_pe_weight,
//   o_pe_psum, o_pe_val            registered array operands and strobe
//   i_pe_psum, i_pe_psum_val       array result and per-kernel valid
//   o_result, o_result_val,
//   i_result_rdy                   pixel result handshake
//   o_busy, o_done, o_err          status: busy level, done pulse, sticky errors
//
// o_err bits: [0] array timeout, [1] partial psum valid, [2] start while busy,
//             [3] zero-sized job. All other bits read as zero.
module kcpe_scheduler #(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_KERNEL  = 4,
    parameter int CGRP_WIDTH  = 8,
    parameter int PIX_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int TIMEOUT     = 64,
    parameter int REG_WIDTH   = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_start,
    input  logic [CGRP_WIDTH-1:0]                    i_num_cgrp,
    input  logic [PIX_WIDTH-1:0]                     i_num_pix,
    output logic                                     o_buf_rd,
    output logic [ADDR_WIDTH-1:0]                    o_data_addr,
    output logic [ADDR_WIDTH-1:0]                    o_weight_addr,
    input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]            i_buf_data,
    input  logic [BIT_WIDTH*NUM_KERNEL*NUM_CHANNEL-1:0] i_buf_weight,
    output logic [BIT_WIDTH*NUM_CHANNEL-1:0]            o_pe_data,
    output logic [BIT_WIDTH*NUM_KERNEL*NUM_CHANNEL-1:0] o_pe_weight,
    output logic [BIT_WIDTH*NUM_KERNEL-1:0]          o_pe_psum,
    output logic                                     o_pe_val,
    input  logic [BIT_WIDTH*NUM_KERNEL-1:0]          i_pe_psum,
    input  logic [NUM_KERNEL-1:0]                    i_pe_psum_val,
    output logic [BIT_WIDTH*NUM_KERNEL-1:0]          o_result,
    output logic                                     o_result_val,
    input  logic                                     i_result_rdy,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic [REG_WIDTH-1:0]                     o_err
);

    localparam int DATA_W = BIT_WIDTH * NUM_CHANNEL;
    localparam int WGT_W  = BIT_WIDTH * NUM_KERNEL * NUM_CHANNEL;
    localparam int PSUM_W = BIT_WIDTH * NUM_KERNEL;
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam int ERR_W  = 4;

    localparam logic [CGRP_WIDTH-1:0] CGRP_ZERO = {CGRP_WIDTH{1'b0}};
    localparam logic [CGRP_WIDTH-1:0] CGRP_ONE  = {{(CGRP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PIX_WIDTH-1:0]  PIX_ZERO  = {PIX_WIDTH{1'b0}};
    localparam logic [PIX_WIDTH-1:0]  PIX_ONE   = {{(PIX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PSUM_W-1:0]     PSUM_ZERO = {PSUM_W{1'b0}};
    localparam logic [NUM_KERNEL-1:0] VAL_ZERO  = {NUM_KERNEL{1'b0}};
    localparam logic [NUM_KERNEL-1:0] VAL_ONES  = {NUM_KERNEL{1'b1}};
    localparam logic [TCNT_W-1:0]     TCNT_ZERO = {TCNT_W{1'b0}};
    localparam logic [TCNT_W-1:0]     TCNT_ONE  = {{(TCNT_W-1){1'b0}}, 1'b1};
    localparam logic [TCNT_W-1:0]     TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CAPT  = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  state_r, state_s;
    logic [CGRP_WIDTH-1:0]   num_cgrp_r, num_cgrp_s;
    logic [PIX_WIDTH-1:0]    num_pix_r, num_pix_s;
    logic [CGRP_WIDTH-1:0]   cgrp_r, cgrp_s;
    logic [PIX_WIDTH-1:0]    pix_r, pix_s;
    logic [PSUM_W-1:0]       psum_r, psum_s;
    logic [TCNT_W-1:0]       wait_cnt_r, wait_cnt_s;
    logic [ERR_W-1:0]        err_r, err_s;

    logic                    buf_rd_s;
    logic [ADDR_WIDTH-1:0]   data_addr_s, weight_addr_s;
    logic [DATA_W-1:0]       pe_data_s;
    logic [WGT_W-1:0]        pe_weight_s;
    logic [PSUM_W-1:0]       pe_psum_s;
    logic                    pe_val_s;
    logic [PSUM_W-1:0]       result_s;
    logic                    result_val_s;
    logic                    busy_s, done_s;
    logic                    psum_full_s, psum_part_s;

    assign o_err = {{(REG_WIDTH-ERR_W){1'b0}}, err_r};

    // Next-state, counter, operand and status logic; every output is the registered copy of a *_s value.
    always_comb begin
        state_s       = state_r;
        num_cgrp_s    = num_cgrp_r;
        num_pix_s     = num_pix_r;
        cgrp_s        = cgrp_r;
        pix_s         = pix_r;
        psum_s        = psum_r;
        wait_cnt_s    = wait_cnt_r;
        pe_data_s     = o_pe_data;
        pe_weight_s   = o_pe_weight;
        pe_psum_s     = o_pe_psum;
        pe_val_s      = 1'b0;
        result_s      = o_result;
        result_val_s  = o_result_val;
        buf_rd_s      = 1'b0;
        data_addr_s   = o_data_addr;
        weight_addr_s = o_weight_addr;

        psum_full_s = (i_pe_psum_val == VAL_ONES);
        psum_part_s = (i_pe_psum_val != VAL_ZERO) && (i_pe_psum_val != VAL_ONES);

        // Error updates that may occur in any state; an accepted start overrides them below.
        err_s    = err_r;
        err_s[1] = err_r[1] | ((state_r == S_WAIT) & psum_part_s);
        err_s[2] = err_r[2] | (i_start & (state_r != S_IDLE));

        case (state_r)
            S_IDLE: begin
                if (i_start) begin
                    num_cgrp_s = i_num_cgrp;
                    num_pix_s  = i_num_pix;
                    cgrp_s     = CGRP_ZERO;
                    pix_s      = PIX_ZERO;
                    psum_s     = PSUM_ZERO;
                    if ((i_num_cgrp == CGRP_ZERO) || (i_num_pix == PIX_ZERO)) begin
                        err_s   = 4'b1000;
                        state_s = S_DONE;
                    end else begin
                        err_s   = 4'b0000;
                        state_s = S_FETCH;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                state_s = S_CAPT;
            end
            S_CAPT: begin
                // Buffer read data is valid this cycle; the first group starts from a zero psum.
                pe_data_s   = i_buf_data;
                pe_weight_s = i_buf_weight;
                pe_psum_s   = (cgrp_r == CGRP_ZERO) ? PSUM_ZERO : psum_r;
                pe_val_s    = 1'b1;
                wait_cnt_s  = TCNT_ZERO;
                state_s     = S_WAIT;
            end
            S_WAIT: begin
                if (psum_full_s) begin
                    psum_s = i_pe_psum;
                    if (cgrp_r < (num_cgrp_r - CGRP_ONE)) begin
                        cgrp_s  = cgrp_r + CGRP_ONE;
                        state_s = S_FETCH;
                    end else begin
                        result_s     = i_pe_psum;
                        result_val_s = 1'b1;
                        state_s      = S_OUT;
                    end
                end else if (wait_cnt_r == TCNT_LAST) begin
                    err_s[0] = 1'b1;
                    state_s  = S_DONE;
                end else begin
                    wait_cnt_s = wait_cnt_r + TCNT_ONE;
                end
            end
            S_OUT: begin
                if (o_result_val && i_result_rdy) begin
                    result_val_s = 1'b0;
                    if (pix_r < (num_pix_r - PIX_ONE)) begin
                        pix_s   = pix_r + PIX_ONE;
                        cgrp_s  = CGRP_ZERO;
                        state_s = S_FETCH;
                    end else begin
                        state_s = S_DONE;
                    end
                end else begin
                    state_s = S_OUT;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // The read strobe and addresses are registered on entry to FETCH so they are visible during FETCH.
        if (state_s == S_FETCH) begin
            buf_rd_s      = 1'b1;
            data_addr_s   = ADDR_WIDTH'(pix_s) * ADDR_WIDTH'(num_cgrp_s) + ADDR_WIDTH'(cgrp_s);
            weight_addr_s = ADDR_WIDTH'(cgrp_s);
        end else begin
            buf_rd_s = 1'b0;
        end

        busy_s = (state_s != S_IDLE);
        done_s = (state_s == S_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            num_cgrp_r    <= CGRP_ZERO;
            num_pix_r     <= PIX_ZERO;
            cgrp_r        <= CGRP_ZERO;
            pix_r         <= PIX_ZERO;
            psum_r        <= PSUM_ZERO;
            wait_cnt_r    <= TCNT_ZERO;
            err_r         <= 4'b0000;
            o_buf_rd      <= 1'b0;
            o_data_addr   <= {ADDR_WIDTH{1'b0}};
            o_weight_addr <= {ADDR_WIDTH{1'b0}};
            o_pe_data     <= {DATA_W{1'b0}};
            o_pe_weight   <= {WGT_W{1'b0}};
            o_pe_psum     <= PSUM_ZERO;
            o_pe_val      <= 1'b0;
            o_result      <= PSUM_ZERO;
            o_result_val  <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state_r       <= state_s;
            num_cgrp_r    <= num_cgrp_s;
            num_pix_r     <= num_pix_s;
            cgrp_r        <= cgrp_s;
            pix_r         <= pix_s;
            psum_r        <= psum_s;
            wait_cnt_r    <= wait_cnt_s;
            err_r         <= err_s;
            o_buf_rd      <= buf_rd_s;
            o_data_addr   <= data_addr_s;
            o_weight_addr <= weight_addr_s;
            o_pe_data     <= pe_data_s;
            o_pe_weight   <= pe_weight_s;
            o_pe_psum     <= pe_psum_s;
            o_pe_val      <= pe_val_s;
            o_result      <= result_s;
            o_result_val  <= result_val_s;
            o_busy        <= busy_s;
            o_done        <= done_s;
        end
    end

endmodule

// File: tb/tb_kcpe_scheduler.sv
// Directed testbench for kcpe_scheduler. A buffer model and an array stub
// (latency L) answer the DUT; a monitor pops expected read addresses, operands
// and results from scoreboard queues filled when each job is launched.
module tb_kcpe_scheduler;

    localparam int L = 2;

    logic         clk;
    logic         rst;
    logic         i_start;
    logic [7:0]   i_num_cgrp;
    logic [15:0]  i_num_pix;
    logic         o_buf_rd;
    logic [15:0]  o_data_addr;
    logic [15:0]  o_weight_addr;
    logic [23:0]  i_buf_data;
    logic [95:0]  i_buf_weight;
    logic [23:0]  o_pe_data;
    logic [95:0]  o_pe_weight;
    logic [31:0]  o_pe_psum;
    logic         o_pe_val;
    logic [31:0]  i_pe_psum;
    logic [3:0]   i_pe_psum_val;
    logic [31:0]  o_result;
    logic         o_result_val;
    logic         i_result_rdy;
    logic         o_busy;
    logic         o_done;
    logic [31:0]  o_err;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] q_daddr[$];
    logic [15:0] q_waddr[$];
    logic [31:0] q_psum[$];
    logic [31:0] q_res[$];

    // stub modes: 0 constant psum, 1 add one per kernel, 2 never valid, 3 partial then full
    int          stub_mode;
    logic [31:0] stub_const;
    int          stub_cnt;
    bit          stub_pend;

    kcpe_scheduler dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_num_cgrp(i_num_cgrp), .i_num_pix(i_num_pix),
        .o_buf_rd(o_buf_rd), .o_data_addr(o_data_addr), .o_weight_addr(o_weight_addr),
        .i_buf_data(i_buf_data), .i_buf_weight(i_buf_weight),
        .o_pe_data(o_pe_data), .o_pe_weight(o_pe_weight), .o_pe_psum(o_pe_psum), .o_pe_val(o_pe_val),
        .i_pe_psum(i_pe_psum), .i_pe_psum_val(i_pe_psum_val),
        .o_result(o_result), .o_result_val(o_result_val), .i_result_rdy(i_result_rdy),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] data_fn(input logic [15:0] a);
        return {8'hD0, a};
    endfunction

    function automatic logic [95:0] weight_fn(input logic [15:0] a);
        return {16'hBEEF, a, 64'h0123456789ABCDEF};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fill the scoreboard for a job of np pixels x ng groups under the given stub mode.
    task automatic plan(input int np, input int ng, input int mode);
        for (int p = 0; p < np; p++) begin
            for (int g = 0; g < ng; g++) begin
                q_daddr.push_back(16'(p * ng + g));
                q_waddr.push_back(16'(g));
                if (g == 0) q_psum.push_back(32'h0);
                else if (mode == 0) q_psum.push_back(stub_const);
                else q_psum.push_back(32'(g) * 32'h01010101);
            end
            if (mode == 0) q_res.push_back(stub_const);
            else q_res.push_back(32'(ng) * 32'h01010101);
        end
    endtask

    task automatic start_job(input logic [7:0] ng, input logic [15:0] np);
        i_num_cgrp = ng;
        i_num_pix  = np;
        i_start    = 1'b1;
        @(negedge clk);
        i_start    = 1'b0;
    endtask

    task automatic run_to_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (!o_done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done_seen"}, o_done, 1);
        check({tag, "_busy_in_done"}, o_busy, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, o_done, 0);
        check({tag, "_idle"}, o_busy, 0);
        check({tag, "_sb_empty"}, q_daddr.size() + q_psum.size() + q_res.size(), 0);
    endtask

    // Buffer model and array stub.
    initial begin
        i_buf_data    = 24'h0;
        i_buf_weight  = 96'h0;
        i_pe_psum     = 32'h0;
        i_pe_psum_val = 4'b0000;
        stub_cnt      = 0;
        stub_pend     = 1'b0;
        forever begin
            @(negedge clk);
            i_pe_psum_val = 4'b0000;
            if (o_buf_rd) begin
                i_buf_data   = data_fn(o_data_addr);
                i_buf_weight = weight_fn(o_weight_addr);
            end
            if (stub_pend) begin
                stub_pend     = 1'b0;
                i_pe_psum_val = 4'b1111;
                i_pe_psum     = o_pe_psum + 32'h01010101;
            end else if (stub_cnt != 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    case (stub_mode)
                        0: begin i_pe_psum_val = 4'b1111; i_pe_psum = stub_const; end
                        1: begin i_pe_psum_val = 4'b1111; i_pe_psum = o_pe_psum + 32'h01010101; end
                        3: begin i_pe_psum_val = 4'b0011; i_pe_psum = 32'hDEADBEEF; stub_pend = 1'b1; end
                        default: i_pe_psum_val = 4'b0000;
                    endcase
                end
            end
            if (o_pe_val) stub_cnt = L;
        end
    end

    // Monitor: compares reads, operands and accepted results against the scoreboard.
    initial begin
        logic [15:0] da;
        logic [15:0] wa;
        da = 16'h0;
        wa = 16'h0;
        forever begin
            @(negedge clk);
            #1;
            if (o_buf_rd) begin
                if (q_daddr.size() == 0) check("rd_unexpected", o_buf_rd, 0);
                else begin
                    da = q_daddr.pop_front();
                    wa = q_waddr.pop_front();
                    check("data_addr", o_data_addr, da);
                    check("weight_addr", o_weight_addr, wa);
                end
            end
            if (o_pe_val) begin
                check("pe_data", o_pe_data, data_fn(da));
                check("pe_weight", o_pe_weight, weight_fn(wa));
                if (q_psum.size() == 0) check("pe_val_unexpected", o_pe_val, 0);
                else check("pe_psum", o_pe_psum, q_psum.pop_front());
            end
            if (o_result_val && i_result_rdy) begin
                if (q_res.size() == 0) check("result_unexpected", o_result_val, 0);
                else check("result", o_result, q_res.pop_front());
            end
        end
    end

    // Directed sequence.
    initial begin
        int cyc;
        int dones;
        rst          = 1'b1;
        i_start      = 1'b0;
        i_num_cgrp   = 8'd0;
        i_num_pix    = 16'd0;
        i_result_rdy = 1'b1;
        stub_mode    = 1;
        stub_const   = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ctl", {o_buf_rd, o_pe_val, o_result_val, o_busy, o_done}, 0);
        check("rst_addr", {o_data_addr, o_weight_addr}, 0);
        check("rst_pe_data", o_pe_data, 0);
        check("rst_pe_weight", o_pe_weight, 0);
        check("rst_psum_result", {o_pe_psum, o_result}, 0);
        check("rst_err", o_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single pixel, single group, constant stub result.
        stub_mode  = 0;
        stub_const = 32'h04030201;
        plan(1, 1, 0);
        start_job(8'd1, 16'd1);
        check("t1_first_rd_latency", o_buf_rd, 1);
        run_to_done("t1", 200, cyc);
        check("t1_cycles", cyc, L + 4);
        check("t1_err", o_err, 0);

        // Two pixels, three groups, psum fed back each group.
        stub_mode = 1;
        plan(2, 3, 1);
        start_job(8'd3, 16'd2);
        run_to_done("t2", 300, cyc);
        check("t2_cycles", cyc, 2 * (3 * (L + 3) + 1));
        check("t2_err", o_err, 0);

        // Backpressure on the result port.
        i_result_rdy = 1'b0;
        plan(2, 1, 1);
        start_job(8'd1, 16'd2);
        cyc = 0;
        while (!o_result_val && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_val_seen", o_result_val, 1);
        repeat (10) begin
            @(negedge clk);
            check("bp_result_stable", {o_result_val, o_result}, {1'b1, 32'h01010101});
            check("bp_no_rd", o_buf_rd, 0);
        end
        i_result_rdy = 1'b1;
        @(negedge clk);
        check("bp_resume_rd", o_buf_rd, 1);
        run_to_done("t3", 200, cyc);
        check("t3_err", o_err, 0);

        // Array never answers: timeout abort, no result.
        stub_mode = 2;
        q_daddr.push_back(16'h0);
        q_waddr.push_back(16'h0);
        q_psum.push_back(32'h0);
        start_job(8'd1, 16'd1);
        run_to_done("t4", 200, cyc);
        check("t4_cycles", cyc, 64 + 2);
        check("t4_err", o_err, 32'h1);

        // Partial valid then full valid.
        stub_mode = 3;
        plan(1, 2, 1);
        start_job(8'd2, 16'd1);
        run_to_done("t5", 200, cyc);
        check("t5_cycles", cyc, 2 * (L + 4) + 1);
        check("t5_err", o_err, 32'h2);

        // Zero channel groups: immediate done with err[3].
        start_job(8'd0, 16'd5);
        check("t6_done", {o_done, o_busy}, 2'b11);
        check("t6_err", o_err, 32'h8);
        @(negedge clk);
        check("t6_idle", {o_done, o_busy}, 2'b00);

        // Start while busy is flagged and ignored.
        stub_mode = 1;
        plan(1, 1, 1);
        start_job(8'd1, 16'd1);
        @(negedge clk);
        i_num_cgrp = 8'd0;
        i_num_pix  = 16'd0;
        i_start    = 1'b1;
        @(negedge clk);
        i_start    = 1'b0;
        run_to_done("t7", 200, cyc);
        check("t7_err", o_err, 32'h4);

        // Reset mid-job aborts without a done pulse.
        plan(1, 3, 1);
        start_job(8'd3, 16'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q_daddr.delete();
        q_waddr.delete();
        q_psum.delete();
        q_res.delete();
        check("t8_rst_state", {o_busy, o_buf_rd, o_pe_val, o_result_val}, 0);
        check("t8_rst_err", o_err, 0);
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        check("t8_no_done", dones, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
